// File: rtl/m_dm_responder_if.sv
// M-stage data-memory request/response bus.
// The master is the M-stage controller and the slave is the data-memory responder.
interface m_dm_responder_if;
    logic        M_req;
    logic        M_DM_WE;
    logic [31:0] M_addr;
    logic [31:0] M_Wdata;
    logic [31:0] M_PC;
    logic [31:0] M_Rdata;
    logic        M_ready;
    logic        M_err;
    logic        M_stall;

    modport master (
        output M_req, M_DM_WE, M_addr, M_Wdata, M_PC,
        input  M_Rdata, M_ready, M_err, M_stall
    );

    modport slave (
        input  M_req, M_DM_WE, M_addr, M_Wdata, M_PC,
        output M_Rdata, M_ready, M_err, M_stall
    );
endinterface

// File: rtl/m_dm_responder.sv
// Data-memory responder: accepts one lw/sw request at a time and services it after LATENCY wait cycles.
// It answers with a one-cycle M_ready pulse and holds M_stall while the request is outstanding.
module m_dm_responder #(
    parameter int unsigned DEPTH_WORDS = 3072,
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned LATENCY     = 2
) (
    input  logic            clk,
    input  logic            reset,
    m_dm_responder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0]  CNT_INIT   = 4'(LATENCY - 1);
    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);

    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic accept, service;

    logic        we_q;
    logic [31:0] addr_q, wdata_q, pc_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [31:0] mem [DEPTH_WORDS];

    logic              in_range;
    logic [ADDR_W-1:0] widx;

    assign widx     = addr_q[ADDR_W+1:2];
    assign in_range = (addr_q < ADDR_LIMIT) && (addr_q[31:ADDR_W+2] == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        service = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.M_req) begin
                    accept  = 1'b1;
                    cnt_d   = CNT_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    service = 1'b1;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Only the latched copies are serviced, so the requester may change its inputs after accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            pc_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (accept) begin
                we_q    <= bus.M_DM_WE;
                addr_q  <= bus.M_addr;
                wdata_q <= bus.M_Wdata;
                pc_q    <= bus.M_PC;
            end
            if (service) begin
                err_q <= ~in_range;
                if (we_q) begin
                    if (in_range) begin
                        mem[widx] <= wdata_q;
`ifndef SYNTHESIS
                        $display("@%h: *%h <= %h", pc_q, {addr_q[31:2], 2'b00}, wdata_q);
`endif
                    end
                end else begin
                    rdata_q <= in_range ? mem[widx] : '0;
                end
            end
        end
    end

    assign bus.M_ready = (state_q == RESP);
    assign bus.M_Rdata = rdata_q;
    assign bus.M_err   = err_q;
    assign bus.M_stall = bus.M_req & ~bus.M_ready;
endmodule

// File: tb/tb_m_dm_responder.sv
// Self-checking bench for m_dm_responder: a table of requests checked through a response scoreboard,
// plus sequences for mid-request changes, reset during WAIT, and LATENCY=1/15 timing.
module tb_m_dm_responder;
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] pc = 32'h0040_0000;
    vec_t sb_q[$];
    vec_t vecs[13];

    m_dm_responder_if b2();
    m_dm_responder_if b1();
    m_dm_responder_if b15();

    m_dm_responder #(.DEPTH_WORDS(3072), .ADDR_W(12), .LATENCY(2))
        u_dut2 (.clk(clk), .reset(reset), .bus(b2));
    m_dm_responder #(.DEPTH_WORDS(3072), .ADDR_W(12), .LATENCY(1))
        u_dut1 (.clk(clk), .reset(reset), .bus(b1));
    m_dm_responder #(.DEPTH_WORDS(3072), .ADDR_W(12), .LATENCY(15))
        u_dut15 (.clk(clk), .reset(reset), .bus(b15));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every response of the LATENCY=2 instance must match the oldest pending request
    always @(negedge clk) begin : monitor
        vec_t e;
        if (b2.M_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: got 1 expected 0");
            end else begin
                e = sb_q.pop_front();
                if (!e.we) check("rdata", b2.M_Rdata, e.exp_rdata);
                check("err", {31'b0, b2.M_err}, {31'b0, e.exp_err});
            end
        end
    end

    task automatic run_req(input vec_t v, input bit corrupt, input bit drop);
        bit got = 1'b0;
        bit stall_ok = 1'b1;
        b2.M_req   = 1'b1;
        b2.M_DM_WE = v.we;
        b2.M_addr  = v.addr;
        b2.M_Wdata = v.wdata;
        b2.M_PC    = pc;
        pc = pc + 32'd4;
        sb_q.push_back(v);
        for (int cyc = 0; cyc < 40 && !got; cyc++) begin
            @(negedge clk);
            if (b2.M_ready) begin
                got = 1'b1;
                check("latency2_cycle", cyc, 3);
                check("stall_in_resp", {31'b0, b2.M_stall}, 32'd0);
            end else if (!drop || cyc == 0) begin
                if (b2.M_stall !== 1'b1) stall_ok = 1'b0;
            end
            @(posedge clk);
            #1;
            if (cyc == 0 && corrupt) begin
                b2.M_addr  = v.addr ^ 32'h4;
                b2.M_Wdata = ~v.wdata;
            end
            if (cyc == 0 && drop) b2.M_req = 1'b0;
        end
        b2.M_req = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL timeout_ready: got 0 expected 1");
        end
        check("stall_while_pending", {31'b0, stall_ok}, 32'd1);
    endtask

    task automatic set_lat(input bit big, input logic req, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata);
        if (big) begin
            b15.M_req = req; b15.M_DM_WE = we; b15.M_addr = addr; b15.M_Wdata = wdata;
        end else begin
            b1.M_req = req; b1.M_DM_WE = we; b1.M_addr = addr; b1.M_Wdata = wdata;
        end
    endtask

    task automatic lat_req(input bit big, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_rdata, input int exp_cyc);
        bit got = 1'b0;
        set_lat(big, 1'b1, we, addr, wdata);
        for (int cyc = 0; cyc < 40 && !got; cyc++) begin
            @(negedge clk);
            if (big ? b15.M_ready : b1.M_ready) begin
                got = 1'b1;
                check(big ? "latency15_cycle" : "latency1_cycle", cyc, exp_cyc);
                if (!we) check(big ? "lat15_rdata" : "lat1_rdata", big ? b15.M_Rdata : b1.M_Rdata, exp_rdata);
            end
            @(posedge clk);
            #1;
        end
        set_lat(big, 1'b0, 1'b0, '0, '0);
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL timeout_lat_ready: got 0 expected 1");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b0, 32'h0000_0000, 32'h0,         32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b1, 32'h0000_0010, 32'h1234_5678, 32'h0,         1'b0};
        vecs[2]  = '{1'b0, 32'h0000_0010, 32'h0,         32'h1234_5678, 1'b0};
        vecs[3]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1'b0};
        vecs[4]  = '{1'b0, 32'h0000_0013, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[5]  = '{1'b0, 32'h0000_3000, 32'h0,         32'h0000_0000, 1'b1};
        vecs[6]  = '{1'b1, 32'h0000_3000, 32'h1111_1111, 32'h0,         1'b1};
        vecs[7]  = '{1'b0, 32'h0000_2FFC, 32'h0,         32'h0000_0000, 1'b0};
        vecs[8]  = '{1'b1, 32'h0000_2FFC, 32'hCAFE_F00D, 32'h0,         1'b0};
        vecs[9]  = '{1'b0, 32'h0000_2FFF, 32'h0,         32'hCAFE_F00D, 1'b0};
        vecs[10] = '{1'b0, 32'h8000_0010, 32'h0,         32'h0000_0000, 1'b1};
        vecs[11] = '{1'b1, 32'h0000_0004, 32'hA5A5_A5A5, 32'h0,         1'b0};
        vecs[12] = '{1'b0, 32'h0000_0006, 32'h0,         32'hA5A5_A5A5, 1'b0};

        reset = 1'b0;
        b2.M_req = 1'b0;  b2.M_DM_WE = 1'b0;  b2.M_addr = '0;  b2.M_Wdata = '0;  b2.M_PC = '0;
        b1.M_req = 1'b0;  b1.M_DM_WE = 1'b0;  b1.M_addr = '0;  b1.M_Wdata = '0;  b1.M_PC = '0;
        b15.M_req = 1'b0; b15.M_DM_WE = 1'b0; b15.M_addr = '0; b15.M_Wdata = '0; b15.M_PC = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", {31'b0, b2.M_ready}, 32'd0);
        check("reset_rdata", b2.M_Rdata, 32'd0);
        check("reset_err", {31'b0, b2.M_err}, 32'd0);
        check("reset_stall", {31'b0, b2.M_stall}, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) run_req(vecs[i], 1'b0, 1'b0);

        // The latched address and data must win over changes made while the request waits
        run_req(vec_t'{1'b1, 32'h40, 32'h0102_0304, 32'h0, 1'b0}, 1'b1, 1'b0);
        run_req(vec_t'{1'b0, 32'h44, 32'h0, 32'h0, 1'b0}, 1'b0, 1'b0);
        run_req(vec_t'{1'b0, 32'h40, 32'h0, 32'h0102_0304, 1'b0}, 1'b0, 1'b1);

        // Reset while a store waits: the store is discarded and memory is cleared
        b2.M_req = 1'b1; b2.M_DM_WE = 1'b1; b2.M_addr = 32'h20; b2.M_Wdata = 32'h7777_7777;
        @(posedge clk);
        #1;
        b2.M_req = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("midreset_ready", {31'b0, b2.M_ready}, 32'd0);
        check("midreset_rdata", b2.M_Rdata, 32'd0);
        check("midreset_err", {31'b0, b2.M_err}, 32'd0);
        check("midreset_stall", {31'b0, b2.M_stall}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        run_req(vec_t'{1'b0, 32'h20, 32'h0, 32'h0, 1'b0}, 1'b0, 1'b0);
        run_req(vec_t'{1'b0, 32'h10, 32'h0, 32'h0, 1'b0}, 1'b0, 1'b0);

        // Back-to-back requests at the extremes of the latency range
        lat_req(1'b0, 1'b1, 32'h8, 32'hABCD_0001, 32'h0, 2);
        lat_req(1'b0, 1'b0, 32'h8, 32'h0, 32'hABCD_0001, 2);
        lat_req(1'b0, 1'b0, 32'hC, 32'h0, 32'h0, 2);
        lat_req(1'b1, 1'b1, 32'h8, 32'h5555_AAAA, 32'h0, 16);
        lat_req(1'b1, 1'b0, 32'h8, 32'h0, 32'h5555_AAAA, 16);

        repeat (2) @(negedge clk);
        check("lat1_idle_ready", {31'b0, b1.M_ready}, 32'd0);
        check("lat15_idle_ready", {31'b0, b15.M_ready}, 32'd0);
        check("scoreboard_empty", sb_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
